// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Size code 2'b11 behaves as a full word.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
// Purely combinational; BIG_ENDIAN selects which bit lanes byte 0 occupies.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int BIG_ENDIAN = 0
) (
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [1:0]  w_lane;
    logic [4:0]  w_shift;
    logic [31:0] w_mask;
    logic [31:0] w_shifted;

    // Pick the bit lane, shift it down for loads, and build the merge mask for stores.
    always_comb begin
        w_lane    = 2'b00;
        w_shift   = 5'd0;
        w_mask    = 32'hFFFF_FFFF;
        w_shifted = i_word;
        o_load    = i_word;
        if (is_word(i_size)) begin
            w_lane = 2'b00;
        end else if (i_size == SZ_B) begin
            w_lane = (BIG_ENDIAN != 0) ? ~i_offset : i_offset;
        end else begin
            w_lane = (BIG_ENDIAN != 0) ? {~i_offset[1], 1'b0} : {i_offset[1], 1'b0};
        end
        w_shift   = {w_lane, 3'b000};
        w_shifted = i_word >> w_shift;
        if (is_word(i_size)) begin
            w_mask = 32'hFFFF_FFFF;
            o_load = i_word;
        end else if (i_size == SZ_B) begin
            w_mask = 32'h0000_00FF << w_shift;
            o_load = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
        end else begin
            w_mask = 32'h0000_FFFF << w_shift;
            o_load = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
        end
        o_merged = (i_word & ~w_mask) | ((i_wdata << w_shift) & w_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed Memory.
// Sub-word stores are read-modify-write; one request in flight at a time.
// Optional macro LSU_MISALIGN_CHECK_EN: misaligned half/word requests complete
// immediately with resp_err=1 and no Memory traffic. Without it, misaligned
// low address bits are dropped and the access is performed aligned.
//
// state   | meaning
// IDLE    | waiting for a request, req_ready high
// RD      | mem_read strobe for load or RMW read
// CAP     | mem_rdata valid: extract load lane or merge store lane
// WR      | mem_write strobe with merged/full word
// DONE    | resp_valid pulse
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int BIG_ENDIAN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    state_e              r_state;
    logic                r_write;
    logic                r_signed;
    logic [1:0]          r_size;
    logic [1:0]          r_off;
    logic [31:0]         r_wdata;
    logic [ADDR_W-1:0]   r_word_idx;
    logic [31:0]         r_mem_wdata;
    logic [31:0]         r_rdata;
    logic                r_err;

    logic                w_misalign;
    logic [1:0]          w_off;
    logic [31:0]         w_load;
    logic [31:0]         w_merged;

    // Lane offset with the bits that do not matter for the access size cleared,
    // plus misalignment detection when the check is built in.
    always_comb begin
        if (req_size == SZ_B) begin
            w_off = req_addr[1:0];
        end else if (req_size == SZ_H) begin
            w_off = {req_addr[1], 1'b0};
        end else begin
            w_off = 2'b00;
        end
`ifdef LSU_MISALIGN_CHECK_EN
        w_misalign = ((req_size == SZ_H) && req_addr[0]) ||
                     (is_word(req_size) && (req_addr[1:0] != 2'b00));
`else
        w_misalign = 1'b0;
`endif
    end

    lsu_lane_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_align (
        .i_word   (mem_rdata),
        .i_wdata  (r_wdata),
        .i_offset (r_off),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    // Request sequencing FSM with registered datapath outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_write     <= 1'b0;
            r_signed    <= 1'b0;
            r_size      <= SZ_B;
            r_off       <= 2'b00;
            r_wdata     <= 32'd0;
            r_word_idx  <= '0;
            r_mem_wdata <= 32'd0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_signed   <= req_signed;
                        r_size     <= req_size;
                        r_off      <= w_off;
                        r_wdata    <= req_wdata;
                        r_word_idx <= {2'b00, req_addr[ADDR_W-1:2]};
                        r_rdata    <= 32'd0;
                        r_err      <= w_misalign;
                        if (w_misalign) begin
                            r_state <= ST_DONE;
                        end else if (req_write && is_word(req_size)) begin
                            r_mem_wdata <= req_wdata;
                            r_state     <= ST_WR;
                        end else begin
                            r_state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    r_state <= ST_CAP;
                end
                ST_CAP: begin
                    if (r_write) begin
                        r_mem_wdata <= w_merged;
                        r_state     <= ST_WR;
                    end else begin
                        r_rdata <= w_load;
                        r_state <= ST_DONE;
                    end
                end
                ST_WR: begin
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes and handshakes decode from state so reset drops them at once.
    assign req_ready  = (r_state == ST_IDLE);
    assign mem_read   = (r_state == ST_RD);
    assign mem_write  = (r_state == ST_WR);
    assign resp_valid = (r_state == ST_DONE);
    assign mem_addr   = r_word_idx;
    assign mem_wdata  = r_mem_wdata;
    assign resp_rdata = r_rdata;
`ifdef LSU_MISALIGN_CHECK_EN
    assign resp_err   = r_err;
`else
    assign resp_err   = 1'b0;
`endif

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the word-addressed data Memory in the multicycle CPU, between the datapath and the Memory's Adress/WriteData/MemRead/MemWrite/MemData pins.
- Turns one byte-addressed load/store request (byte, half, word; signed/unsigned) into Memory strobes.
- Sub-word stores are done as read-modify-write. Load data is extracted and extended before return.
- Single outstanding request; valid/ready handshake towards the datapath.

Parameters:
- ADDR_W, 32, width of the byte address from the datapath and of mem_addr.
- BIG_ENDIAN, 0, lane order: 0 = byte 0 at bits [7:0]; 1 = byte 0 at bits [31:24].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_signed  input  1  sign-extend loads; ignored for stores.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores.
- resp_err  output  1  misaligned request; qualified by resp_valid.
- mem_addr  output  ADDR_W  word index = {2'b00, addr[ADDR_W-1:2]}.
- mem_wdata  output  32  merged word to Memory.
- mem_read  output  1  Memory read strobe.
- mem_write  output  1  Memory write strobe.
- mem_rdata  input  32  Memory data; valid the cycle after mem_read was high at a rising edge.

Behaviour:
- Reset: state IDLE. req_ready=1. All other outputs 0, including resp_rdata and mem_wdata.
- Acceptance: handshake completes at the rising edge where req_valid & req_ready. addr, size, signed, write and wdata are latched at that edge.
- States: IDLE, RD, CAP, WR, DONE. All outputs are registered or decoded from state only; none depends combinationally on req_*.
- Load: IDLE -> RD (mem_read=1, 1 cycle) -> CAP (mem_rdata sampled; lane extracted/extended into resp_rdata) -> DONE (resp_valid=1) -> IDLE.
  - resp_valid is high 3 cycles after the accept edge.
- Word store: IDLE -> WR (mem_write=1, mem_wdata=wdata) -> DONE -> IDLE.
  - resp_valid is high 2 cycles after the accept edge.
- Sub-word store: IDLE -> RD -> CAP (merge wdata lane into mem_rdata, other lanes preserved) -> WR -> DONE.
  - resp_valid is high 4 cycles after the accept edge.
- Strobe rules:
  - mem_read and mem_write are never high together.
  - mem_addr holds the latched word index from RD through WR.
- Lane select:
  - Byte uses addr[1:0].
  - Half uses addr[1]; BIG_ENDIAN swaps lane order.
- Extension: req_signed=1 replicates bit 7 or bit 15; otherwise zero-fill.
- Address wrap: no depth check. Bits above the Memory depth alias in the Memory.
- Reset mid-operation: immediate return to IDLE. Strobes drop asynchronously. A pending RMW write is abandoned and the Memory word is untouched. No resp_valid is issued.
- req_valid while busy: ignored, no queueing. Requester must hold until req_ready.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: a half with addr[0]=1, or a word with addr[1:0]!=0, goes IDLE -> DONE with resp_err=1 and resp_rdata=0. No mem_read or mem_write is issued.
- Undefined: misaligned low bits are forced to 0 (aligned access). resp_err is tied 0.

Decomposition:
- Package lsu_pkg:
  - Size encodings SZ_B, SZ_H, SZ_W.
  - State encodings ST_IDLE, ST_RD, ST_CAP, ST_WR, ST_DONE.
- Sub-module lsu_lane_align (combinational):
  - Inputs: word, offset, size, signed, BIG_ENDIAN.
  - Outputs: extracted/extended load value, and merged store word.

Test Plan:
- Memory word 3 = 0x8899AABB, little-endian. Signed byte load @0x0D -> mem_addr=3, mem_read one cycle; resp_rdata=0xFFFFFFAA, resp_valid 3 cycles after accept.
- Unsigned half load @0x0E, same word -> resp_rdata=0x00008899.
- Byte store 0x5C @0x0C -> RD, CAP, then WR with mem_wdata=0x8899AA5C; resp_valid 4 cycles after accept; word 3 reads back 0x8899AA5C.
- Word store 0x12345678 @0x10 -> mem_addr=4, mem_write exactly 1 cycle, mem_read never high; resp_valid 2 cycles after accept.
- Word load @0x11:
  - Macro defined -> resp_err=1, resp_rdata=0, no mem strobes.
  - Macro undefined -> aligned word 4 returned, resp_err=0.
- Assert rst during CAP of a byte store -> mem_write never asserted, no resp_valid, word unchanged, req_ready=1 next cycle.
